// File: rtl/byte_lane_dly_loader_if.sv
//==============================================================================
// byte_lane_dly_loader_if : command-side and PHY-side signals of the delay loader.
// Optional readback port enabled by BYTE_LANE_DLY_LOADER_READBACK_EN. Rev 1.0
//==============================================================================
`default_nettype none

interface byte_lane_dly_loader_if #(
  parameter int LANE_AW = 2
);
  localparam int NL = 2**LANE_AW;

  logic                 wr_en;
  logic [LANE_AW+4:0]   wr_addr;
  logic [7:0]           wr_data;
  logic                 start;
  logic [NL-1:0]        lane_mask;
  logic [8*NL-1:0]      dly_data;
  logic [4:0]           dly_addr;
  logic [NL-1:0]        ld_delay;
  logic                 set;
  logic                 busy;
  logic                 done;
`ifdef BYTE_LANE_DLY_LOADER_READBACK_EN
  logic [LANE_AW+4:0]   rd_addr;
  logic [7:0]           rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, start, lane_mask, rd_addr,
    input  dly_data, dly_addr, ld_delay, set, busy, done, rd_data
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, lane_mask, rd_addr,
    output dly_data, dly_addr, ld_delay, set, busy, done, rd_data
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start, lane_mask,
    input  dly_data, dly_addr, ld_delay, set, busy, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, lane_mask,
    output dly_data, dly_addr, ld_delay, set, busy, done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/byte_lane_dly_loader.sv
//==============================================================================
// byte_lane_dly_loader : shadow delay table streamed into PHY byte lanes, then set.
// Optional readback port: BYTE_LANE_DLY_LOADER_READBACK_EN. Rev 1.0
//==============================================================================
`default_nettype none

module byte_lane_dly_loader #(
  parameter int LANE_AW  = 2,
  parameter int OUT_LAST = 9,
  parameter int IN_LAST  = 8
) (
  input  wire logic             clk_div,
  input  wire logic             rst,
  byte_lane_dly_loader_if.slave bus
);

  localparam int          c_NL        = 2**LANE_AW;
  localparam int          c_ENTRIES   = c_NL * 32;
  localparam logic [4:0]  c_OUT_LAST  = 5'(OUT_LAST);
  localparam logic [4:0]  c_LAST_STEP = 5'(16 + IN_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SET  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_table [0:c_ENTRIES-1];
  logic [4:0]          r_dly_addr;
  logic [8*c_NL-1:0]   r_dly_data;
  logic [c_NL-1:0]     r_mask;
  logic                r_done;
  logic [4:0]          w_rd_addr;
  logic [4:0]          w_step_nxt;
  logic [8*c_NL-1:0]   w_rd_data;
  logic                w_advance;
  logic                w_accept;
  logic                w_wr_ok;
  logic [c_NL-1:0]     w_ld_delay;
  logic                w_set;
  logic                w_busy;

  assign w_wr_ok    = bus.wr_en && (r_state == S_IDLE);
  assign w_step_nxt = (r_dly_addr == c_OUT_LAST) ? 5'd16 : r_dly_addr + 5'd1;

  always_ff @(posedge clk_div) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The read address runs one step ahead of dly_addr so the registered table read lines up.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_addr   = r_dly_addr;
    w_advance   = 1'b0;
    w_accept    = 1'b0;
    w_ld_delay  = '0;
    w_set       = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_rd_addr   = 5'd0;
          w_advance   = 1'b1;
          w_accept    = 1'b1;
        end
      end
      S_LOAD: begin
        w_busy     = 1'b1;
        w_ld_delay = r_mask;
        if (r_dly_addr == c_LAST_STEP) begin
          w_state_nxt = S_SET;
        end else begin
          w_rd_addr = w_step_nxt;
          w_advance = 1'b1;
        end
      end
      S_SET: begin
        w_busy      = 1'b1;
        w_set       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_div) begin
    if (w_wr_ok) r_table[bus.wr_addr] <= bus.wr_data;
  end

  // Forward a same-cycle write so a start issued with a write sees the new value.
  for (genvar k = 0; k < c_NL; k++) begin : g_lane
    logic [LANE_AW+4:0] w_idx;
    assign w_idx = {LANE_AW'(k), w_rd_addr};
    assign w_rd_data[8*k +: 8] = (w_wr_ok && (bus.wr_addr == w_idx)) ? bus.wr_data
                                                                     : r_table[w_idx];
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_dly_addr <= 5'd0;
      r_dly_data <= '0;
      r_mask     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_SET);
      if (w_accept) r_mask <= bus.lane_mask;
      if (w_advance) begin
        r_dly_addr <= w_rd_addr;
        r_dly_data <= w_rd_data;
      end
    end
  end

`ifdef BYTE_LANE_DLY_LOADER_READBACK_EN
  logic [7:0] r_rd_data;

  always_ff @(posedge clk_div) begin
    if (rst) r_rd_data <= 8'd0;
    else     r_rd_data <= r_table[bus.rd_addr];
  end

  assign bus.rd_data = r_rd_data;
`endif

  assign bus.dly_addr = r_dly_addr;
  assign bus.dly_data = r_dly_data;
  assign bus.ld_delay = w_ld_delay;
  assign bus.set      = w_set;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_byte_lane_dly_loader.sv
//==============================================================================
// tb_byte_lane_dly_loader : scoreboard bench for byte_lane_dly_loader.
// Readback checks compiled with BYTE_LANE_DLY_LOADER_READBACK_EN. Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_byte_lane_dly_loader;

  localparam int LANE_AW = 2;

  logic clk_div = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_div = ~clk_div;

  byte_lane_dly_loader_if #(.LANE_AW(LANE_AW)) bus ();

  byte_lane_dly_loader #(
    .LANE_AW (LANE_AW),
    .OUT_LAST(9),
    .IN_LAST (8)
  ) dut (
    .clk_div(clk_div),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic        busy;
    logic [3:0]  ld;
    logic        set;
    logic        done;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] m_tab [4][32];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT shows activity consumes one expected record.
  always @(negedge clk_div) begin
    rec_t a;
    rec_t e;
    if (bus.busy || bus.done) begin
      a = '{busy: bus.busy, ld: bus.ld_delay, set: bus.set, done: bus.done,
            addr: bus.dly_addr, data: bus.dly_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected nothing", a);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("seq_addr%0d", e.addr), 64'(a), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic wr(input int lane, input int a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = {2'(lane), 5'(a)};
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    m_tab[lane][a] = d;
  endtask

  task automatic push_step(input logic [3:0] mask, input int a);
    rec_t r;
    r = '{busy: 1'b1, ld: mask, set: 1'b0, done: 1'b0, addr: 5'(a),
          data: {m_tab[3][a], m_tab[2][a], m_tab[1][a], m_tab[0][a]}};
    exp_q.push_back(r);
  endtask

  task automatic push_seq(input logic [3:0] mask);
    rec_t r;
    for (int a = 0; a <= 9; a++)   push_step(mask, a);
    for (int a = 16; a <= 24; a++) push_step(mask, a);
    r = '{busy: 1'b1, ld: 4'h0, set: 1'b1, done: 1'b0, addr: 5'd24,
          data: {m_tab[3][24], m_tab[2][24], m_tab[1][24], m_tab[0][24]}};
    exp_q.push_back(r);
    r.busy = 1'b0;
    r.set  = 1'b0;
    r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic start_seq(input logic [3:0] mask);
    bus.lane_mask = mask;
    bus.start     = 1'b1;
    push_seq(mask);
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.done) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 32; a++) m_tab[l][a] = 8'h00;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.lane_mask = '0;
`ifdef BYTE_LANE_DLY_LOADER_READBACK_EN
    bus.rd_addr = '0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_set",      64'(bus.set),      64'd0);
    chk("rst_ld_delay", 64'(bus.ld_delay), 64'd0);
    chk("rst_dly_addr", 64'(bus.dly_addr), 64'd0);
    chk("rst_dly_data", 64'(bus.dly_data), 64'd0);
`ifdef BYTE_LANE_DLY_LOADER_READBACK_EN
    chk("rst_rd_data",  64'(bus.rd_data),  64'd0);
`endif
    rst = 1'b0;
    tick();

    // Test 1: table[k][a] = {k, a, 1}, e.g. lane 2 addr 17 = 8'hA3.
    for (int l = 0; l < 4; l++) begin
      for (int a = 0; a <= 9; a++)   wr(l, a, {2'(l), 5'(a), 1'b1});
      for (int a = 16; a <= 24; a++) wr(l, a, {2'(l), 5'(a), 1'b1});
    end
    chk("model_l2_a17", 64'(m_tab[2][17]), 64'h A3);
    start_seq(4'hF);
    wait_idle();

    // Test 2: partial mask with lane 1 addr 8 overwritten.
    wr(1, 8, 8'hA5);
    start_seq(4'b0101);
    wait_idle();

    // Empty mask still runs the whole sequence.
    start_seq(4'h0);
    wait_idle();

    // Test 3: start and write during step 5 are both ignored.
    start_seq(4'hF);
    repeat (5) tick();
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 7'd0;
    bus.wr_data = 8'hFF;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    wait_idle();
    start_seq(4'hF);
    wait_idle();

    // Test 4: reset during step 10.
    start_seq(4'hF);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_busy",     64'(bus.busy),     64'd0);
    chk("midrst_ld_delay", 64'(bus.ld_delay), 64'd0);
    chk("midrst_set",      64'(bus.set),      64'd0);
    chk("midrst_dly_addr", 64'(bus.dly_addr), 64'd0);
    chk("midrst_dly_data", 64'(bus.dly_data), 64'd0);
    repeat (3) tick();
    start_seq(4'hF);
    wait_idle();

    // Test 5: start in the done cycle; wr and start together in that cycle too.
    start_seq(4'hF);
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = {2'd2, 5'd0};
    bus.wr_data = 8'h5A;
    m_tab[2][0] = 8'h5A;
    start_seq(4'h3);
    bus.wr_en = 1'b0;
    chk("restart_busy", 64'(bus.busy),     64'd1);
    chk("restart_ld",   64'(bus.ld_delay), 64'h3);
    wait_idle();

`ifdef BYTE_LANE_DLY_LOADER_READBACK_EN
    // Test 6: readback idle and busy.
    wr(3, 17, 8'h3C);
    bus.rd_addr = {2'd3, 5'd17};
    tick();
    chk("rb_idle", 64'(bus.rd_data), 64'h3C);
    start_seq(4'hF);
    tick();
    chk("rb_busy", 64'(bus.rd_data), 64'h3C);
    bus.rd_addr = {2'd0, 5'd5};
    tick();
    chk("rb_busy_l0a5", 64'(bus.rd_data), 64'h0B);
    wait_idle();
`endif

    repeat (3) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
